register_file_write_arbiter: RTL and testbench
==============================================

# register_file_write_arbiter

Round-robin arbiter that shares the single write port of `register_file` between several requesters, such as the ALU writeback, load unit and debug port. Each requester presents a register index and data with a valid/ready handshake. The arbiter grants at most one request per cycle and drives the register file's `write_register`, `write_data` and `write_enable` from a registered output stage. It sits directly in front of `register_file`; the read path is untouched.

## Interface
- `NUM_REQUESTERS`, default 3: number of requesters, 2..8.
- `ADDR_WIDTH`, default 2: register index width; must match `register_file`.
- `DATA_WIDTH`, default 32: write data width; must match `register_file`.

Ports (clock and reset first):
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `request_valid`  in  NUM_REQUESTERS  requester i has a pending write.
- `request_register`  in  NUM_REQUESTERS*ADDR_WIDTH  destination index; slice i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `request_data`  in  NUM_REQUESTERS*DATA_WIDTH  write data; slice i at [i*DATA_WIDTH +: DATA_WIDTH].
- `request_ready`  out  NUM_REQUESTERS  one-hot grant; the request is accepted on a cycle with valid & ready.
- `write_hold`  in  1  when high, nothing is granted this cycle.
- `write_register`  out  ADDR_WIDTH  to `register_file` `write_register`.
- `write_data`  out  DATA_WIDTH  to `register_file` `write_data`.
- `write_enable`  out  1  to `register_file` `write_enable`.
- `grant_index`  out  $clog2(NUM_REQUESTERS)  requester whose write is currently on the port.

## Operation
- State: round-robin priority pointer `next_priority` (0..NUM_REQUESTERS-1), plus output registers for `write_register`, `write_data`, `write_enable` and `grant_index`.
- Arbitration is combinational each cycle. If `write_hold`=0, scan requesters starting at `next_priority` and wrapping modulo NUM_REQUESTERS; the first with `request_valid`=1 gets `request_ready`=1. All other `request_ready` bits are 0.
- `request_ready` is at most one-hot. It is never asserted when `write_hold`=1, when `reset_n`=0, or for a requester whose valid is 0.
- On an accepting edge with winner i:
  - `write_register` ← slice i of `request_register`.
  - `write_data` ← slice i of `request_data`.
  - `write_enable` ← 1.
  - `grant_index` ← i.
  - `next_priority` ← (i+1) mod NUM_REQUESTERS.
- On an edge with no acceptance:
  - `write_enable` ← 0.
  - `write_register`, `write_data` and `grant_index` hold their values.
  - `next_priority` is unchanged.
- Requester rule: once valid is high, the requester keeps valid high and register/data stable until accepted. The arbiter does not check this.
- Requests to the same register index from different requesters are serialized in grant order, so the last granted write wins. The arbiter does no merging.
- Reset value of every output, applied asynchronously while `reset_n`=0:
  - `write_enable`=0, `write_register`=0, `write_data`=0, `grant_index`=0.
  - `request_ready`=0.
  - Internally, `next_priority`=0.
- Reset mid-operation: an accepted-but-not-yet-written request is dropped, and `write_enable` falls immediately. The requester sees it as accepted.

## Timing
- Latency from acceptance edge to `write_enable` high is 1 cycle. `write_enable` stays high for exactly 1 cycle per accepted request.
- Throughput is 1 write per cycle. Back-to-back grants to different requesters are allowed. The same requester can win consecutive cycles only when it is the sole valid requester.
- Fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQUESTERS cycles.
- `write_hold` acts combinationally in the same cycle. Deasserting it lets grants resume in that cycle, from the unchanged pointer.
- First edge after `reset_n` rises: a valid request can be accepted, with requester 0 at highest priority.

## Configuration
- `REGISTER_ZERO_PROTECT_EN` defined:
  - Requests to register index 0 are still arbitered, accepted and advance the pointer, with `grant_index` updated.
  - For those requests `write_enable` is forced to 0, so register 0 is never written.
- `REGISTER_ZERO_PROTECT_EN` undefined: index 0 is written like any other register.

## Test plan
- Reset, then requester 1 valid with register 2, data 84: ready[1] asserted in the same cycle; next cycle `write_enable`=1, `write_register`=2, `write_data`=84, `grant_index`=1; following cycle `write_enable`=0.
- All 3 requesters held valid (data 21, 42, 168) for 6 cycles: grant order 0,1,2,0,1,2; `write_data` sequence 21,42,168,21,42,168; `write_enable` high 6 consecutive cycles.
- Requesters 0 and 2 valid, `write_hold`=1 for 3 cycles: `request_ready`=0 and `write_enable`=0 throughout; on release, requester 0 is granted first, then requester 2.
- Requesters 0 and 1 both write register 3 (data 1, then 2): two writes issued in grant order; a read of register 3 from `register_file` afterwards returns 2.
- `reset_n` pulled low in the cycle `write_enable`=1: `write_enable` drops to 0 immediately, all outputs return to 0, and the next grant after release goes to requester 0.
- With `REGISTER_ZERO_PROTECT_EN`, a request to register 0 with data 99: ready asserted and `grant_index` updates, but `write_enable` stays 0; without the macro, `write_enable`=1 with `write_data`=99.

Source files
------------

// File: rtl/register_file_write_arbiter_if.sv
// Purpose : bundles the requester handshake and the register-file write port
//           of register_file_write_arbiter into one parameterised interface.
// Modports: slave  = arbiter side (takes requests, drives the write port)
//           master = requester/register-file side (drives requests, sees grants)
// Signals :
//   request_valid    [N]      requester i has a pending write
//   request_register [N*AW]   destination index, slice i at [i*AW +: AW]
//   request_data     [N*DW]   write data, slice i at [i*DW +: DW]
//   request_ready    [N]      one-hot grant, accepted on valid & ready
//   write_hold                suppresses all grants in the current cycle
//   write_register/write_data/write_enable  registered write port
//   grant_index               requester whose write is on the port
interface register_file_write_arbiter_if #(
    parameter int NUM_REQUESTERS = 3,
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 32
);
    localparam int INDEX_WIDTH = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    logic [NUM_REQUESTERS-1:0]            request_valid;
    logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] request_register;
    logic [NUM_REQUESTERS*DATA_WIDTH-1:0] request_data;
    logic [NUM_REQUESTERS-1:0]            request_ready;
    logic                                 write_hold;
    logic [ADDR_WIDTH-1:0]                write_register;
    logic [DATA_WIDTH-1:0]                write_data;
    logic                                 write_enable;
    logic [INDEX_WIDTH-1:0]               grant_index;

    modport slave (
        input  request_valid,
        input  request_register,
        input  request_data,
        input  write_hold,
        output request_ready,
        output write_register,
        output write_data,
        output write_enable,
        output grant_index
    );

    modport master (
        output request_valid,
        output request_register,
        output request_data,
        output write_hold,
        input  request_ready,
        input  write_register,
        input  write_data,
        input  write_enable,
        input  grant_index
    );
endinterface

// File: rtl/register_file_write_arbiter.sv
// Purpose     : round-robin arbiter sharing the single register_file write port.
// Latency     : grant is combinational; write_enable pulses 1 cycle after acceptance.
// Backpressure: request_ready only for the round-robin winner; write_hold stalls all.
// Ports:
//   clock, reset_n  single rising-edge clock, asynchronous active-low reset
//   bus (slave)     requester handshake in, registered write port + grant_index out
// Optional feature: define REGISTER_ZERO_PROTECT_EN to suppress write_enable for
// accepted writes targeting register index 0 (they still arbitrate normally).
module register_file_write_arbiter #(
    parameter int NUM_REQUESTERS = 3,
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                          clock,
    input  logic                          reset_n,
    register_file_write_arbiter_if.slave  bus
);
    localparam int INDEX_WIDTH = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int SUM_WIDTH   = INDEX_WIDTH + 1;
    localparam int PAD_WIDTH   = 1 << INDEX_WIDTH;

    logic [INDEX_WIDTH-1:0]    next_priority;
    logic [PAD_WIDTH-1:0]      valid_pad;
    logic [SUM_WIDTH-1:0]      scan_sum;
    logic [INDEX_WIDTH-1:0]    scan_idx;
    logic                      grant_found;
    logic [INDEX_WIDTH-1:0]    winner;
    logic [NUM_REQUESTERS-1:0] grant;
    logic [ADDR_WIDTH-1:0]     sel_register;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic                      write_commit;
    logic [INDEX_WIDTH-1:0]    priority_after_winner;

    logic [ADDR_WIDTH-1:0]     write_register_q;
    logic [DATA_WIDTH-1:0]     write_data_q;
    logic                      write_enable_q;
    logic [INDEX_WIDTH-1:0]    grant_index_q;

    // Scan requesters starting at next_priority, wrapping modulo NUM_REQUESTERS.
    // valid is zero-padded to a power of two so the scan index never selects
    // outside the vector for non-power-of-two requester counts.
    always_comb begin
        valid_pad                      = '0;
        valid_pad[NUM_REQUESTERS-1:0]  = bus.request_valid;
        scan_sum                       = '0;
        scan_idx                       = '0;
        grant_found                    = 1'b0;
        winner                         = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            scan_sum = {1'b0, next_priority} + SUM_WIDTH'(k);
            if (scan_sum >= SUM_WIDTH'(NUM_REQUESTERS)) begin
                scan_sum = scan_sum - SUM_WIDTH'(NUM_REQUESTERS);
            end
            scan_idx = scan_sum[INDEX_WIDTH-1:0];
            if (!grant_found && valid_pad[scan_idx]) begin
                grant_found = 1'b1;
                winner      = scan_idx;
            end
        end
        // Reset gating keeps ready low while reset_n is asserted, even
        // though the pointer is already forced to 0 asynchronously.
        if (bus.write_hold || !reset_n) begin
            grant_found = 1'b0;
        end
    end

    // One-hot grant and selection of the winner's register/data slices.
    always_comb begin
        grant        = '0;
        sel_register = '0;
        sel_data     = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant_found && (winner == INDEX_WIDTH'(i))) begin
                grant[i]     = 1'b1;
                sel_register = bus.request_register[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data     = bus.request_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef REGISTER_ZERO_PROTECT_EN
    // Accepted writes to index 0 still consume the grant but never reach the file.
    assign write_commit = grant_found && (sel_register != '0);
`else
    assign write_commit = grant_found;
`endif

    assign priority_after_winner = (winner == INDEX_WIDTH'(NUM_REQUESTERS - 1))
                                   ? '0 : winner + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            next_priority    <= '0;
            write_register_q <= '0;
            write_data_q     <= '0;
            write_enable_q   <= 1'b0;
            grant_index_q    <= '0;
        end else if (grant_found) begin
            next_priority    <= priority_after_winner;
            write_register_q <= sel_register;
            write_data_q     <= sel_data;
            write_enable_q   <= write_commit;
            grant_index_q    <= winner;
        end else begin
            write_enable_q   <= 1'b0;
        end
    end

    assign bus.request_ready  = grant;
    assign bus.write_register = write_register_q;
    assign bus.write_data     = write_data_q;
    assign bus.write_enable   = write_enable_q;
    assign bus.grant_index    = grant_index_q;

endmodule

// File: tb/tb_register_file_write_arbiter.sv
// Directed bench for register_file_write_arbiter (3 requesters, 2-bit index,
// 32-bit data). Inputs change 1 time unit after the rising edge; outputs are
// sampled in the same low-activity window. A tiny register-file model captures
// the write port so write ordering to one index can be observed.
module tb_register_file_write_arbiter;
    localparam int N  = 3;
    localparam int AW = 2;
    localparam int DW = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    register_file_write_arbiter_if #(
        .NUM_REQUESTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) bus ();

    register_file_write_arbiter #(
        .NUM_REQUESTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [DW-1:0] rf_model [4];
    always @(posedge clock) begin
        if (bus.write_enable) rf_model[bus.write_register] <= bus.write_data;
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
        bus.request_register[i*AW +: AW] = r;
        bus.request_data[i*DW +: DW]     = d;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    int            order [6] = '{0, 1, 2, 0, 1, 2};
    logic [DW-1:0] dval  [3] = '{32'd21, 32'd42, 32'd168};
    logic          exp_we_zero;

    initial begin
        bus.request_valid    = '0;
        bus.request_register = '0;
        bus.request_data     = '0;
        bus.write_hold       = 1'b0;

        // Reset state
        #2;
        check("rst_we",   bus.write_enable,   0);
        check("rst_wr",   bus.write_register, 0);
        check("rst_wd",   bus.write_data,     0);
        check("rst_gi",   bus.grant_index,    0);
        bus.request_valid = '1;
        #1;
        check("rst_ready", bus.request_ready, 0);
        bus.request_valid = '0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;

        // Single request from requester 1
        set_req(1, 2'd2, 32'd84);
        bus.request_valid = 3'b010;
        #1;
        check("t1_ready", bus.request_ready, 3'b010);
        step();
        bus.request_valid = '0;
        check("t1_we", bus.write_enable,   1);
        check("t1_wr", bus.write_register, 2);
        check("t1_wd", bus.write_data,     84);
        check("t1_gi", bus.grant_index,    1);
        #1;
        check("t1_ready_off", bus.request_ready, 0);
        step();
        check("t1_we_off",  bus.write_enable,   0);
        check("t1_wr_hold", bus.write_register, 2);
        check("t1_gi_hold", bus.grant_index,    1);

        // Fairness with all requesters continuously valid
        do_reset();
        set_req(0, 2'd1, 32'd21);
        set_req(1, 2'd2, 32'd42);
        set_req(2, 2'd3, 32'd168);
        bus.request_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("rr_ready", bus.request_ready, 64'd1 << order[c]);
            step();
            check("rr_we", bus.write_enable, 1);
            check("rr_gi", bus.grant_index,  order[c]);
            check("rr_wd", bus.write_data,   dval[order[c]]);
        end
        bus.request_valid = '0;
        step();
        check("rr_we_off", bus.write_enable, 0);

        // write_hold stalls, then grants resume from the unchanged pointer
        bus.request_valid = 3'b101;
        bus.write_hold    = 1'b1;
        repeat (3) begin
            #1;
            check("hold_ready", bus.request_ready, 0);
            step();
            check("hold_we", bus.write_enable, 0);
        end
        bus.write_hold = 1'b0;
        #1;
        check("rel_ready0", bus.request_ready, 3'b001);
        step();
        bus.request_valid = 3'b100;
        check("rel_gi0", bus.grant_index, 0);
        check("rel_wd0", bus.write_data,  21);
        check("rel_we0", bus.write_enable, 1);
        #1;
        check("rel_ready2", bus.request_ready, 3'b100);
        step();
        bus.request_valid = '0;
        check("rel_gi2", bus.grant_index, 2);
        check("rel_wd2", bus.write_data,  168);
        step();
        check("rel_we_off", bus.write_enable, 0);

        // Two requesters writing the same register: last grant wins
        set_req(0, 2'd3, 32'd1);
        set_req(1, 2'd3, 32'd2);
        bus.request_valid = 3'b011;
        #1;
        check("same_ready0", bus.request_ready, 3'b001);
        step();
        bus.request_valid = 3'b010;
        check("same_gi0", bus.grant_index, 0);
        check("same_wd0", bus.write_data,  1);
        step();
        bus.request_valid = '0;
        check("same_gi1", bus.grant_index,    1);
        check("same_wr1", bus.write_register, 3);
        check("same_wd1", bus.write_data,     2);
        step();
        check("same_rf3", rf_model[3], 2);

        // Reset while write_enable is high
        set_req(2, 2'd1, 32'h55);
        bus.request_valid = 3'b100;
        #1;
        check("mid_ready", bus.request_ready, 3'b100);
        step();
        bus.request_valid = '0;
        check("mid_we_pre", bus.write_enable, 1);
        reset_n = 1'b0;
        #1;
        check("mid_we", bus.write_enable,   0);
        check("mid_wr", bus.write_register, 0);
        check("mid_wd", bus.write_data,     0);
        check("mid_gi", bus.grant_index,    0);
        bus.request_valid = 3'b111;
        #1;
        check("mid_ready_rst", bus.request_ready, 0);
        reset_n = 1'b1;
        #1;
        check("mid_ready_rel", bus.request_ready, 3'b001);
        step();
        bus.request_valid = '0;
        check("mid_gi_rel", bus.grant_index, 0);
        check("mid_wd_rel", bus.write_data,  1);
        step();

        // Write to register 0 (suppressed only with the protect macro)
`ifdef REGISTER_ZERO_PROTECT_EN
        exp_we_zero = 1'b0;
`else
        exp_we_zero = 1'b1;
`endif
        set_req(1, 2'd0, 32'd99);
        bus.request_valid = 3'b010;
        #1;
        check("z_ready", bus.request_ready, 3'b010);
        step();
        bus.request_valid = '0;
        check("z_gi", bus.grant_index,    1);
        check("z_wr", bus.write_register, 0);
        check("z_wd", bus.write_data,     99);
        check("z_we", bus.write_enable,   exp_we_zero);

        // Sole valid requester wins consecutive cycles
        set_req(2, 2'd2, 32'd7);
        bus.request_valid = 3'b100;
        #1;
        check("sole_ready0", bus.request_ready, 3'b100);
        step();
        check("sole_gi0", bus.grant_index, 2);
        check("sole_we0", bus.write_enable, 1);
        check("sole_ready1", bus.request_ready, 3'b100);
        step();
        bus.request_valid = '0;
        check("sole_gi1", bus.grant_index, 2);
        check("sole_we1", bus.write_enable, 1);
        step();
        check("sole_we_off", bus.write_enable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
